// File: rtl/frame_renderer_pkg.sv
// Shared definitions for the frame renderer: raster defaults, coordinate width,
// FSM state encoding and the rectangle span test.
package frame_renderer_pkg;

  localparam int H_RES_DEFAULT = 640;
  localparam int V_RES_DEFAULT = 480;
  localparam int COORD_W       = 10;

  typedef logic [COORD_W-1:0] coordT;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RENDER = 2'd1,
    DONE   = 2'd2
  } stateT;

  // Widened to 11 bits so origin+size never wraps; clipping falls out naturally.
  function automatic logic inSpan(input coordT p, input coordT origin, input coordT size);
    logic [COORD_W:0] lo;
    logic [COORD_W:0] hi;
    lo = {1'b0, origin};
    hi = {1'b0, origin} + {1'b0, size};
    return ({1'b0, p} >= lo) && ({1'b0, p} < hi);
  endfunction

endpackage

// File: rtl/pixel_counter.sv
// Raster x/y counter: clears to (0,0), advances left-to-right then top-to-bottom,
// and flags the final pixel of the frame.
module pixel_counter
  import frame_renderer_pkg::*;
#(
  parameter int H_RES = H_RES_DEFAULT,
  parameter int V_RES = V_RES_DEFAULT
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               clear,
  input  logic               advance,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               last
);

  localparam coordT X_MAX = COORD_W'(H_RES - 1);
  localparam coordT Y_MAX = COORD_W'(V_RES - 1);

  coordT xReg;
  coordT yReg;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      xReg <= '0;
      yReg <= '0;
    end else if (clear) begin
      xReg <= '0;
      yReg <= '0;
    end else if (advance) begin
      if (xReg == X_MAX) begin
        xReg <= '0;
        yReg <= (yReg == Y_MAX) ? '0 : yReg + 1'b1;
      end else begin
        xReg <= xReg + 1'b1;
      end
    end
  end

  assign x    = xReg;
  assign y    = yReg;
  assign last = (xReg == X_MAX) && (yReg == Y_MAX);

endmodule

// File: rtl/frame_renderer.sv
// Renders one frame of a solid rectangle over a background colour, emitting one
// pixel per accepted write into a downstream double buffer.
module frame_renderer
  import frame_renderer_pkg::*;
#(
  parameter int H_RES = H_RES_DEFAULT,
  parameter int V_RES = V_RES_DEFAULT
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               start,
  input  logic [COORD_W-1:0] rectX,
  input  logic [COORD_W-1:0] rectY,
  input  logic [COORD_W-1:0] rectW,
  input  logic [COORD_W-1:0] rectH,
  input  logic [23:0]        rectColor,
  input  logic [23:0]        bgColor,
  input  logic               writeReady,
  output logic               writeEnable,
  output logic [7:0]         outRed,
  output logic [7:0]         outGreen,
  output logic [7:0]         outBlue,
  output logic [COORD_W-1:0] outX,
  output logic [COORD_W-1:0] outY,
  output logic               busy,
  output logic               frameDone
);

  stateT stateReg;
  stateT stateNext;

  coordT       rectXReg;
  coordT       rectYReg;
  coordT       rectWReg;
  coordT       rectHReg;
  logic [23:0] rectColorReg;
  logic [23:0] bgColorReg;

  coordT       pixX;
  coordT       pixY;
  logic        pixLast;
  logic        latchFrame;
  logic        emitPixel;
  logic        insideRect;
  logic [23:0] pixColor;

  assign latchFrame = (stateReg == IDLE) && start;
  assign emitPixel  = (stateReg == RENDER) && writeReady;

  pixel_counter #(
    .H_RES(H_RES),
    .V_RES(V_RES)
  ) uCounter (
    .clk    (clk),
    .rstN   (rstN),
    .clear  (latchFrame),
    .advance(emitPixel),
    .x      (pixX),
    .y      (pixY),
    .last   (pixLast)
  );

  // A zero width or height makes the span empty, so that frame is all background.
  assign insideRect = inSpan(pixX, rectXReg, rectWReg) && inSpan(pixY, rectYReg, rectHReg);
  assign pixColor   = insideRect ? rectColorReg : bgColorReg;

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      IDLE:    if (start) stateNext = RENDER;
      RENDER:  if (writeReady && pixLast) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      stateReg <= IDLE;
    end else begin
      stateReg <= stateNext;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rectXReg     <= '0;
      rectYReg     <= '0;
      rectWReg     <= '0;
      rectHReg     <= '0;
      rectColorReg <= '0;
      bgColorReg   <= '0;
    end else if (latchFrame) begin
      rectXReg     <= rectX;
      rectYReg     <= rectY;
      rectWReg     <= rectW;
      rectHReg     <= rectH;
      rectColorReg <= rectColor;
      bgColorReg   <= bgColor;
    end
  end

  // Colour and coordinate outputs only move on an accepted write; otherwise they hold.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      writeEnable <= 1'b0;
      frameDone   <= 1'b0;
      outRed      <= '0;
      outGreen    <= '0;
      outBlue     <= '0;
      outX        <= '0;
      outY        <= '0;
    end else begin
      writeEnable <= emitPixel;
      frameDone   <= (stateReg == DONE);
      if (emitPixel) begin
        {outRed, outGreen, outBlue} <= pixColor;
        outX <= pixX;
        outY <= pixY;
      end
    end
  end

  assign busy = (stateReg != IDLE);

endmodule

// File: doc/frame_renderer.md
FRAME_RENDERER -- requirements
Module: frame_renderer

Interface
REQ-001 The block SHALL have parameter H_RES, default 640, meaning horizontal pixels per frame.
REQ-002 The block SHALL have parameter V_RES, default 480, meaning lines per frame.
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all logic is clocked on its rising edge.
REQ-004 The block SHALL have port rstN, input, 1, an asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, a request to render one frame.
REQ-006 The block SHALL have ports rectX and rectY, input, 10 each, the rectangle top-left corner.
REQ-007 The block SHALL have ports rectW and rectH, input, 10 each, the rectangle size.
REQ-008 The block SHALL have port rectColor, input, 24, the rectangle colour as {R,G,B}.
REQ-009 The block SHALL have port bgColor, input, 24, the background colour as {R,G,B}.
REQ-010 The block SHALL have port writeReady, input, 1, meaning the downstream double buffer accepts a pixel this cycle.
REQ-011 The block SHALL have port writeEnable, output, 1, meaning the pixel on outRed/outGreen/outBlue is valid.
REQ-012 The block SHALL have ports outRed, outGreen and outBlue, output, 8 each, the pixel colour for the double-buffer write port.
REQ-013 The block SHALL have ports outX and outY, output, 10 each, the coordinate of the emitted pixel.
REQ-014 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-015 The block SHALL have port frameDone, output, 1, a one-cycle pulse marking the end of a frame.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RENDER and DONE.
REQ-017 In IDLE with start=1, the block SHALL latch rectX/Y/W/H, rectColor and bgColor, clear the x/y counters to 0 and enter RENDER.
REQ-018 Inputs SHALL be ignored outside the IDLE-state latch, and a start while busy SHALL be ignored.
REQ-019 In RENDER with writeReady=1 at an edge, outputs SHALL register pixel (x,y) with writeEnable=1 and the counter SHALL advance (x wraps to 0 at H_RES-1, then y increments).
REQ-020 In RENDER with writeReady=0 at an edge, writeEnable SHALL be 0, the counters SHALL hold, and colour/coordinate outputs SHALL hold their last values.
REQ-021 A pixel SHALL be inside the rectangle iff x>=rectX, x<rectX+rectW, y>=rectY and y<rectY+rectH, with the sums computed at 11 bits (no wrap; the rectangle is clipped at the frame edge).
REQ-022 A pixel inside the rectangle SHALL take rectColor, and any other pixel SHALL take bgColor; rectW=0 or rectH=0 SHALL yield an all-background frame.
REQ-023 After emitting pixel (H_RES-1, V_RES-1), the FSM SHALL enter DONE; DONE SHALL last one cycle with frameDone=1 and writeEnable=0, and SHALL then return to IDLE.
REQ-024 Timing: with start sampled at edge k and writeReady held at 1, writeEnable SHALL be high after edges k+1 .. k+H_RES*V_RES, and frameDone SHALL be high after edge k+H_RES*V_RES+1.
REQ-025 start sampled in DONE SHALL be ignored; a new frame SHALL begin only from IDLE.

Reset
REQ-026 On rstN=0, the block SHALL asynchronously set the state to IDLE, the counters and outX/outY to 0, outRed/outGreen/outBlue to 0, and writeEnable, busy and frameDone to 0.
REQ-027 A reset mid-frame SHALL abort the frame with no frameDone pulse, and the first frame after reset SHALL start at (0,0).

Structure
REQ-028 A shared package SHALL hold the H_RES/V_RES defaults, the 10-bit coordinate width, and the state encoding.
REQ-029 The x/y raster counter with advance and wrap SHALL be a sub-module named pixel_counter.

Verification
REQ-030 Scenario: rect (100,50,20,10) red 0xFF0000, bg 0x0000FF, writeReady=1 -> 307200 writes; exactly 200 are red, at x 100..119 and y 50..59; frameDone high at edge k+307201.
REQ-031 Scenario: rectW=0 -> all 307200 writes are 0x0000FF.
REQ-032 Scenario: rect (630,470,50,50) -> red region clipped to x 630..639, y 470..479 (100 pixels), with no wrap to x<630.
REQ-033 Scenario: writeReady toggles 1,0,0,1 -> no pixel is skipped or duplicated, and the outX/outY sequence is strictly raster order.
REQ-034 Scenario: rstN pulsed low at pixel 1000 -> all outputs go to 0 immediately with no frameDone; the next start emits (0,0) first.
REQ-035 Scenario: start held high throughout -> a second frame begins only from IDLE after the frameDone pulse, with one idle cycle between frames.
